// File: rtl/ws_array_ctrl_if.sv
// ws_array_ctrl_if: job control, weight/activation streams and array-edge signals of ws_array_ctrl.
interface ws_array_ctrl_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
);
    logic                    start;
    logic [CNT_W-1:0]        num_vecs;
    logic                    busy;
    logic                    done;
    logic                    w_valid;
    logic                    w_ready;
    logic [N*DATA_WIDTH-1:0] w_data;
    logic [N-1:0]            b_load;
    logic [N*DATA_WIDTH-1:0] b_row;
    logic                    a_valid;
    logic                    a_ready;
    logic [N*DATA_WIDTH-1:0] a_data;
    logic [N*DATA_WIDTH-1:0] a_row;
    logic                    pe_enable;
    logic [N-1:0]            c_valid;
    modport master (
        output start, num_vecs, w_valid, w_data, a_valid, a_data,
        input  busy, done, w_ready, b_load, b_row, a_ready, a_row, pe_enable, c_valid
    );
    modport slave (
        input  start, num_vecs, w_valid, w_data, a_valid, a_data,
        output busy, done, w_ready, b_load, b_row, a_ready, a_row, pe_enable, c_valid
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// ws_array_ctrl: job sequencer for an N x N weight-stationary systolic array
// (weight row load, skewed activation feed, per-column result tracking).
module ws_array_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input logic          clk,
    input logic          rst,
    ws_array_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N-1:0]            b_load_q, b_load_d;
    logic [N*DATA_WIDTH-1:0] b_row_q, b_row_d;
    logic [2*N-1:0]          tag_q, tag_d;
    logic                    w_hs, a_hs;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        b_load_d = '0;
        b_row_d  = b_row_q;
        w_hs     = bus.w_valid && state_q == LOAD_W;
        a_hs     = bus.a_valid && state_q == COMPUTE;
        tag_d    = {tag_q[2*N-2:0], a_hs};
        if (w_hs) begin
            b_row_d  = bus.w_data;
            b_load_d = N'(1) << cnt_q;
        end
        if (w_hs || a_hs)
            cnt_d = cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD_W;
                num_d   = bus.num_vecs;
                cnt_d   = '0;
            end
            LOAD_W: if (w_hs && cnt_q == CNT_W'(N - 1)) begin
                state_d = (num_q == '0) ? DONE : COMPUTE;
                cnt_d   = '0;
            end
            COMPUTE: if (a_hs && cnt_q == num_q - CNT_W'(1))
                state_d = DRAIN;
            // no new tags enter in DRAIN, so the last vector is the only tag left once it reaches the end
            DRAIN: if (tag_q[2*N-1] && tag_q[2*N-2:0] == '0)
                state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            num_q    <= '0;
            cnt_q    <= '0;
            b_load_q <= '0;
            b_row_q  <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            b_load_q <= b_load_d;
            b_row_q  <= b_row_d;
            tag_q    <= tag_d;
        end
    end

    genvar k;
    for (k = 0; k < N; k++) begin : g_skew
        localparam int W = (k + 1) * DATA_WIDTH;
        logic [W-1:0] sk_q, sk_d;
        always_comb
            sk_d = (sk_q << DATA_WIDTH) | W'(a_hs ? bus.a_data[k*DATA_WIDTH +: DATA_WIDTH] : '0);
        always_ff @(posedge clk)
            sk_q <= rst ? '0 : sk_d;
        assign bus.a_row[k*DATA_WIDTH +: DATA_WIDTH] = sk_q[W-1 -: DATA_WIDTH];
    end

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.w_ready   = state_q == LOAD_W;
    assign bus.a_ready   = state_q == COMPUTE;
    assign bus.pe_enable = state_q == COMPUTE || state_q == DRAIN;
    assign bus.b_load    = b_load_q;
    assign bus.b_row     = b_row_q;
    assign bus.c_valid   = tag_q[2*N-1:N];
endmodule

// File: tb/tb_ws_array_ctrl.sv
// tb_ws_array_ctrl: scoreboard bench for ws_array_ctrl; stimulus queues expected
// cycle-stamped events, a negedge monitor pops and compares them.
module tb_ws_array_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ws_array_ctrl_if #(.N(N), .DATA_WIDTH(DW), .CNT_W(CW)) bus ();
    ws_array_ctrl #(.N(N), .DATA_WIDTH(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit pe_seen = 0;
    int wrow = 0;

    typedef struct packed {
        int                 c;
        logic [N-1:0]       ld;
        logic [N*DW-1:0]    row;
    } bev_t;

    bev_t           bq[$];
    int             aq_c[N][$];
    logic [DW-1:0]  aq_v[N][$];
    int             cq[N][$];
    int             dq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every DUT output event must match the oldest queued expectation
    bev_t          m_b;
    int            m_c;
    logic [DW-1:0] m_v;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pe_enable) pe_seen = 1;
            if (bus.b_load != '0) begin
                if (bq.size() == 0) chk("b_load_unexpected", 64'(bus.b_load), 64'd0);
                else begin
                    m_b = bq.pop_front();
                    chk("b_load_cycle", 64'(cyc), 64'(m_b.c));
                    chk("b_load", 64'(bus.b_load), 64'(m_b.ld));
                    chk("b_row", 64'(bus.b_row), 64'(m_b.row));
                end
            end
            for (int k = 0; k < N; k++) begin
                if (bus.a_row[k*DW +: DW] != '0) begin
                    if (aq_c[k].size() == 0) chk("a_row_unexpected", 64'(bus.a_row[k*DW +: DW]), 64'd0);
                    else begin
                        m_c = aq_c[k].pop_front();
                        m_v = aq_v[k].pop_front();
                        chk("a_row_cycle", 64'(cyc), 64'(m_c));
                        chk("a_row_lane", 64'(bus.a_row[k*DW +: DW]), 64'(m_v));
                    end
                end
            end
            for (int j = 0; j < N; j++) begin
                if (bus.c_valid[j]) begin
                    if (cq[j].size() == 0) chk("c_valid_unexpected", 64'(j), 64'hff);
                    else begin
                        m_c = cq[j].pop_front();
                        chk("c_valid_cycle", 64'(cyc), 64'(m_c));
                    end
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) chk("done_unexpected", 64'(cyc), 64'd0);
                else begin
                    m_c = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(m_c));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        bus.start    = 1'b1;
        bus.num_vecs = CW'(n);
        tick();
        bus.start = 1'b0;
        wrow      = 0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic send_w(input logic [N*DW-1:0] d, input bit zero_job);
        int   t = 0;
        int   h;
        bev_t e;
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        while (!bus.w_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.w_ready) begin
            chk("w_ready_timeout", 64'd0, 64'd1);
            bus.w_valid = 1'b0;
        end else begin
            h      = cyc;
            e.c    = h + 1;
            e.ld   = N'(1) << wrow;
            e.row  = d;
            bq.push_back(e);
            if (wrow == N - 1 && zero_job) dq.push_back(h + 1);
            tick();
            bus.w_valid = 1'b0;
            wrow++;
            if (wrow == N) begin
                chk("w_ready_low_after_load", 64'(bus.w_ready), 64'd0);
                chk("a_ready_after_load", 64'(bus.a_ready), zero_job ? 64'd0 : 64'd1);
            end
        end
    endtask

    task automatic send_a(input logic [N*DW-1:0] d, input bit last);
        int t = 0;
        int h;
        bus.a_valid = 1'b1;
        bus.a_data  = d;
        while (!bus.a_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.a_ready) begin
            chk("a_ready_timeout", 64'd0, 64'd1);
            bus.a_valid = 1'b0;
        end else begin
            h = cyc;
            for (int k = 0; k < N; k++) begin
                aq_c[k].push_back(h + 1 + k);
                aq_v[k].push_back(d[k*DW +: DW]);
            end
            for (int j = 0; j < N; j++) cq[j].push_back(h + 1 + N + j);
            if (last) dq.push_back(h + 2*N + 1);
            tick();
            bus.a_valid = 1'b0;
            if (last) chk("a_ready_low_after_last", 64'(bus.a_ready), 64'd0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 200) begin
            tick();
            t++;
        end
        chk("job_finished", 64'(bus.busy), 64'd0);
    endtask

    task automatic flush();
        bq.delete();
        dq.delete();
        for (int k = 0; k < N; k++) begin
            aq_c[k].delete();
            aq_v[k].delete();
            cq[k].delete();
        end
    endtask

    function automatic int pending();
        int s = bq.size() + dq.size();
        for (int k = 0; k < N; k++) s += aq_c[k].size() + cq[k].size();
        return s;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk(nm, {bus.busy, bus.done, bus.w_ready, bus.a_ready, bus.pe_enable,
                 bus.b_load, bus.c_valid, bus.b_row, bus.a_row}, 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.num_vecs = '0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.a_valid = 1'b0; bus.a_data = '0;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();
        chk_all_zero("idle_outputs");

        // continuous weight load, then one vector with lanes {1,2,3,4}
        start_job(1);
        send_w(32'h01020304, 1'b0);
        send_w(32'h05060708, 1'b0);
        send_w(32'h090A0B0C, 1'b0);
        send_w(32'h0D0E0F10, 1'b0);
        send_a(32'h04030201, 1'b1);
        wait_idle();

        // gapped weight load, three vectors with one bubble before the third
        start_job(3);
        for (int r = 0; r < N; r++) begin
            send_w(32'h11111111 * (r + 1), 1'b0);
            tick();
        end
        send_a(32'h14131211, 1'b0);
        send_a(32'h24232221, 1'b0);
        tick();
        send_a(32'h34333231, 1'b1);
        wait_idle();
        tick();
        chk("queues_drained_jobs", 64'(pending()), 64'd0);

        // reset mid-COMPUTE aborts the job without done
        start_job(5);
        for (int r = 0; r < N; r++) send_w(32'hA0A0A0A0 + 32'(r), 1'b0);
        send_a(32'h01010101, 1'b0);
        send_a(32'h02020202, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        flush();
        chk_all_zero("reset_mid_job");
        for (int i = 0; i < 12; i++) tick();
        chk("idle_after_abort", 64'(bus.busy), 64'd0);

        // zero-vector job with start held through busy
        pe_seen = 0;
        bus.start    = 1'b1;
        bus.num_vecs = '0;
        tick();
        wrow = 0;
        chk("busy_zero_job", 64'(bus.busy), 64'd1);
        for (int r = 0; r < N; r++) send_w(32'h0F0F0F00 + 32'(r), 1'b1);
        chk("done_state_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("idle_after_done", 64'(bus.busy), 64'd0);
        tick();
        chk("restart_after_done", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wrow = 0;
        for (int r = 0; r < N; r++) send_w(32'h55555550 + 32'(r), 1'b1);
        wait_idle();
        chk("pe_enable_never_high", 64'(pe_seen), 64'd0);
        tick();
        tick();
        chk("queues_drained_final", 64'(pending()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
